// File: rtl/sdram_read_arb.sv
// Round-robin arbiter sharing one SDRAM burst-read port among several cache miss handlers.
// Valid/ready: the controller takes the burst on the cycle where sd_readReq && sd_ready are both high at posedge clk.
module sdram_read_arb #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 25,
  parameter int MAX_TRANS = 16,
  parameter int TS_W      = $clog2(MAX_TRANS),
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_cache_to_sdram,
  input  logic [NUM_REQ*TS_W-1:0]   transSize,
  input  logic [NUM_REQ-1:0]        readReq,
  output logic [NUM_REQ-1:0]        readValid_out,
  output logic [NUM_REQ*32-1:0]     readData,
  output logic [NUM_REQ-1:0]        doneRead,
  output logic                      sd_readReq,
  output logic [ADDR_W-1:0]         sd_addr,
  output logic [TS_W-1:0]           sd_size,
  input  logic                      sd_ready,
  input  logic                      sd_rvalid,
  input  logic [31:0]               sd_rdata,
  output logic                      busy,
  output logic                      err_spurious,
  output logic [1:0]                dbg_state,
  output logic [PTR_W-1:0]          dbg_rr_ptr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_grant;
  logic [PTR_W-1:0]   w_pick;
  logic               w_found;
  logic [TS_W-1:0]    r_beat_cnt;
  logic [31:0]        r_rdata;
  logic [ADDR_W-1:0]  w_addr_arr [NUM_REQ];
  logic [TS_W-1:0]    w_size_arr [NUM_REQ];
  logic [NUM_REQ-1:0] w_grant_oh;
  logic               w_grant_en;
  logic               w_accept;
  logic               w_beat;
  logic               w_last;
  logic               w_spurious;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi] = addr_cache_to_sdram[gi*ADDR_W +: ADDR_W];
    assign w_size_arr[gi] = transSize[gi*TS_W +: TS_W];
  end

  assign w_grant_oh = NUM_REQ'(1) << r_grant;
  assign readData   = {NUM_REQ{r_rdata}};
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;
  assign dbg_rr_ptr = r_rr_ptr;

  // First requester at or after rr_ptr, wrapping around the index space.
  always_comb begin : p_pick
    int k;
    k       = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_found && readReq[k[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = k[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_accept    = 1'b0;
    w_beat      = 1'b0;
    w_last      = 1'b0;
    w_spurious  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_spurious = sd_rvalid;
        if (w_found) begin
          w_grant_en  = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_spurious = sd_rvalid;
        if (sd_readReq && sd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (sd_rvalid) begin
          w_beat = 1'b1;
          if (r_beat_cnt == '0) begin
            w_last      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_beat_cnt    <= '0;
      r_rdata       <= '0;
      readValid_out <= '0;
      doneRead      <= '0;
      sd_readReq    <= 1'b0;
      sd_addr       <= '0;
      sd_size       <= '0;
      err_spurious  <= 1'b0;
    end else begin
      readValid_out <= '0;
      doneRead      <= '0;
      if (w_spurious) err_spurious <= 1'b1;
      if (w_grant_en) begin
        r_grant    <= w_pick;
        sd_addr    <= w_addr_arr[w_pick];
        sd_size    <= w_size_arr[w_pick];
        sd_readReq <= 1'b1;
      end
      if (w_accept) begin
        sd_readReq <= 1'b0;
        r_beat_cnt <= sd_size;
      end
      if (w_beat) begin
        r_rdata       <= sd_rdata;
        readValid_out <= w_grant_oh;
        // Count stops at zero on the final beat so it never wraps.
        if (!w_last) r_beat_cnt <= r_beat_cnt - 1'b1;
      end
      if (w_last) begin
        doneRead <= w_grant_oh;
        r_rr_ptr <= (r_grant == PTR_W'(NUM_REQ-1)) ? '0 : r_grant + 1'b1;
      end
    end
  end

endmodule
